// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern subsystem: sequencer states,
// pattern-mode codes and 800x600@60 timing constants.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_BLANK   = 2'd2,
        ST_UNBLANK = 2'd3
    } vga_state_t;

    localparam logic [1:0] MODE_BARS     = 2'd0;
    localparam logic [1:0] MODE_GRID     = 2'd1;
    localparam logic [1:0] MODE_SOLID    = 2'd2;
    localparam logic [1:0] MODE_GRADIENT = 2'd3;

    localparam int H_TOTAL   = 1056;
    localparam int V_TOTAL   = 628;
    localparam int FRAME_CYC = H_TOTAL * V_TOTAL;

    // Blank counter preload: counts remaining frame_starts before the new mode is applied.
    function automatic logic [3:0] blank_preload(input int frames);
        return 4'(frames - 1);
    endfunction

endpackage

// File: rtl/vga_frame_watchdog.sv
// Frame watchdog: counts clocks since the last frame_start and saturates at
// TIMEOUT_CYC; expire stays high while saturated.
module vga_frame_watchdog #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk_40m,
    input  logic rst,
    input  logic clear,
    output logic expire
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_40m or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LIMIT);

endmodule

// File: rtl/vga_mode_sequencer.sv
// Mode sequencer: accepts pattern/colour requests and applies them behind a
// frame-aligned blanking window, with watchdog recovery if frames stop.
module vga_mode_sequencer
    import vga_pkg::*;
#(
    parameter int          BLANK_FRAMES = 2,
    parameter int          TIMEOUT_CYC  = 1000000,
    parameter logic [1:0]  DEF_MODE     = 2'd0,
    parameter logic [23:0] DEF_COLOR    = 24'h000000
) (
    input  logic        clk_40m,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        cfg_valid,
    input  logic [1:0]  cfg_mode,
    input  logic [23:0] cfg_color,
    output logic        cfg_ready,
    output logic [1:0]  pat_sel,
    output logic [23:0] pat_color,
    output logic        video_en,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        timeout_err
);

    vga_state_t  state_q,       state_d;
    logic [1:0]  shadow_mode_q, shadow_mode_d;
    logic [23:0] shadow_color_q, shadow_color_d;
    logic [1:0]  pat_sel_q,     pat_sel_d;
    logic [23:0] pat_color_q,   pat_color_d;
    logic [3:0]  blank_cnt_q,   blank_cnt_d;
    logic [15:0] frame_cnt_q,   frame_cnt_d;
    logic        video_en_q,    video_en_d;
    logic        cfg_ready_q,   cfg_ready_d;
    logic        busy_q,        busy_d;
    logic        timeout_err_q, timeout_err_d;
    logic        accept;
    logic        wd_expire;

    vga_frame_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_40m (clk_40m),
        .rst     (rst),
        .clear   (frame_start),
        .expire  (wd_expire)
    );

    assign accept = cfg_valid & cfg_ready_q;

    always_comb begin
        state_d        = state_q;
        shadow_mode_d  = shadow_mode_q;
        shadow_color_d = shadow_color_q;
        pat_sel_d      = pat_sel_q;
        pat_color_d    = pat_color_q;
        blank_cnt_d    = blank_cnt_q;
        video_en_d     = video_en_q;
        timeout_err_d  = timeout_err_q;
        frame_cnt_d    = frame_cnt_q + 16'(frame_start);

        // A stalled timing generator must never leave the display dark.
        if (state_q != ST_RUN && wd_expire) begin
            pat_sel_d     = shadow_mode_q;
            pat_color_d   = shadow_color_q;
            video_en_d    = 1'b1;
            timeout_err_d = 1'b1;
            state_d       = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (wd_expire) begin
                        timeout_err_d = 1'b1;
                    end
                    if (accept) begin
                        shadow_mode_d  = cfg_mode;
                        shadow_color_d = cfg_color;
                        state_d        = ST_WAIT_VB;
                    end
                end
                ST_WAIT_VB: begin
                    if (frame_start) begin
                        video_en_d  = 1'b0;
                        blank_cnt_d = blank_preload(BLANK_FRAMES);
                        state_d     = ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (frame_start) begin
                        if (blank_cnt_q == 4'd0) begin
                            pat_sel_d   = shadow_mode_q;
                            pat_color_d = shadow_color_q;
                            state_d     = ST_UNBLANK;
                        end else begin
                            blank_cnt_d = blank_cnt_q - 4'd1;
                        end
                    end
                end
                ST_UNBLANK: begin
                    if (frame_start) begin
                        video_en_d = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        cfg_ready_d = (state_d == ST_RUN);
        busy_d      = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_40m or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            shadow_mode_q  <= DEF_MODE;
            shadow_color_q <= DEF_COLOR;
            pat_sel_q      <= DEF_MODE;
            pat_color_q    <= DEF_COLOR;
            blank_cnt_q    <= 4'd0;
            frame_cnt_q    <= 16'd0;
            video_en_q     <= 1'b1;
            cfg_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_mode_q  <= shadow_mode_d;
            shadow_color_q <= shadow_color_d;
            pat_sel_q      <= pat_sel_d;
            pat_color_q    <= pat_color_d;
            blank_cnt_q    <= blank_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            video_en_q     <= video_en_d;
            cfg_ready_q    <= cfg_ready_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign busy        = busy_q;
    assign video_en    = video_en_q;
    assign pat_sel     = pat_sel_q;
    assign pat_color   = pat_color_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Bench for vga_mode_sequencer: directed scenarios plus random traffic,
// all checked every cycle against a frame-counting reference model.
module tb_vga_mode_sequencer;

    localparam int          BF = 2;
    localparam int          TO = 200;
    localparam logic [1:0]  DM = 2'd3;
    localparam logic [23:0] DC = 24'h102030;

    logic        clk_40m = 1'b0;
    logic        rst = 1'b0;
    logic        frame_start = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [23:0] cfg_color = 24'd0;
    logic        cfg_ready;
    logic [1:0]  pat_sel;
    logic [23:0] pat_color;
    logic        video_en;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    vga_mode_sequencer #(
        .BLANK_FRAMES (BF),
        .TIMEOUT_CYC  (TO),
        .DEF_MODE     (DM),
        .DEF_COLOR    (DC)
    ) dut (
        .clk_40m     (clk_40m),
        .rst         (rst),
        .frame_start (frame_start),
        .cfg_valid   (cfg_valid),
        .cfg_mode    (cfg_mode),
        .cfg_color   (cfg_color),
        .cfg_ready   (cfg_ready),
        .pat_sel     (pat_sel),
        .pat_color   (pat_color),
        .video_en    (video_en),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk_40m = ~clk_40m;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: a change in progress is tracked only by how many frame_starts
    // have been seen since the request was taken.
    bit          m_busy, m_video, m_err;
    int          m_n, m_wd;
    logic [1:0]  m_sel, m_sh_mode;
    logic [23:0] m_color, m_sh_color;
    logic [15:0] m_fcnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_video = 1; m_err = 0; m_n = 0; m_wd = 0;
        m_sel = DM; m_color = DC; m_sh_mode = DM; m_sh_color = DC; m_fcnt = 16'd0;
    endtask

    task automatic model_step();
        bit expired;
        expired = (m_wd >= TO);
        if (!m_busy) begin
            if (expired) m_err = 1;
            if (cfg_valid) begin
                m_busy = 1; m_n = 0;
                m_sh_mode = cfg_mode; m_sh_color = cfg_color;
            end
        end else if (expired) begin
            m_sel = m_sh_mode; m_color = m_sh_color;
            m_video = 1; m_err = 1; m_busy = 0;
        end else if (frame_start) begin
            m_n++;
            if (m_n == 1) m_video = 0;
            if (m_n == BF + 1) begin m_sel = m_sh_mode; m_color = m_sh_color; end
            if (m_n == BF + 2) begin m_video = 1; m_busy = 0; end
        end
        m_fcnt = m_fcnt + 16'(frame_start);
        m_wd = frame_start ? 0 : ((m_wd < TO) ? m_wd + 1 : TO);
    endtask

    task automatic step(input logic v, input logic [1:0] md, input logic [23:0] col, input logic fs);
        cfg_valid = v; cfg_mode = md; cfg_color = col; frame_start = fs;
        @(posedge clk_40m);
        model_step();
        #1;
    endtask

    task automatic frame(input int gap, input logic v, input logic [1:0] md, input logic [23:0] col);
        repeat (gap - 1) step(v, md, col, 1'b0);
        step(v, md, col, 1'b1);
    endtask

    task automatic check_reset_values();
        chk("rst_pat_sel",     32'(pat_sel),     32'(DM));
        chk("rst_pat_color",   32'(pat_color),   32'(DC));
        chk("rst_video_en",    32'(video_en),    32'd1);
        chk("rst_cfg_ready",   32'(cfg_ready),   32'd1);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_frame_cnt",   32'(frame_cnt),   32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    endtask

    task automatic do_reset();
        cfg_valid = 0; frame_start = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_values();
        repeat (2) @(posedge clk_40m);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk_40m) begin
        if (chk_en) begin
            chk("cfg_ready",   32'(cfg_ready),   32'(!m_busy));
            chk("busy",        32'(busy),        32'(m_busy));
            chk("video_en",    32'(video_en),    32'(m_video));
            chk("pat_sel",     32'(pat_sel),     32'(m_sel));
            chk("pat_color",   32'(pat_color),   32'(m_color));
            chk("frame_cnt",   32'(frame_cnt),   32'(m_fcnt));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    initial begin
        int  gap;
        logic fs;
        model_reset();
        #1;
        rst = 1'b1;
        #1;
        chk_en = 1'b1;
        check_reset_values();
        repeat (2) @(posedge clk_40m);
        #1;
        rst = 1'b0;

        // First edge after reset accepts; a held second request waits for RUN.
        step(1, 2'd2, 24'hFF0000, 0);
        chk("acc_ready_drop", 32'(cfg_ready), 32'd0);
        chk("acc_busy",       32'(busy),      32'd1);
        frame(100, 1, 2'd1, 24'h00FF00);
        chk("fs1_video_off",  32'(video_en),  32'd0);
        frame(100, 1, 2'd1, 24'h00FF00);
        chk("fs2_sel_hold",   32'(pat_sel),   32'(DM));
        frame(100, 1, 2'd1, 24'h00FF00);
        chk("fs3_sel",        32'(pat_sel),   32'd2);
        chk("fs3_color",      32'(pat_color), 32'hFF0000);
        chk("fs3_video_off",  32'(video_en),  32'd0);
        frame(100, 1, 2'd1, 24'h00FF00);
        chk("fs4_video_on",   32'(video_en),  32'd1);
        chk("fs4_ready",      32'(cfg_ready), 32'd1);
        step(1, 2'd1, 24'h00FF00, 0);
        chk("held_accept",    32'(cfg_ready), 32'd0);
        repeat (4) frame(100, 0, 2'd0, 24'd0);
        chk("held_final_sel", 32'(pat_sel),   32'd1);
        chk("held_final_col", 32'(pat_color), 32'h00FF00);

        // Accept coinciding with frame_start: that pulse does not count.
        frame(50, 0, 2'd0, 24'd0);
        step(1, 2'd3, 24'h0000FF, 1);
        chk("coin_busy",      32'(busy),      32'd1);
        chk("coin_video",     32'(video_en),  32'd1);
        frame(100, 0, 2'd0, 24'd0);
        chk("coin_fs1_off",   32'(video_en),  32'd0);
        frame(100, 0, 2'd0, 24'd0);
        chk("coin_fs2_sel",   32'(pat_sel),   32'd1);
        frame(100, 0, 2'd0, 24'd0);
        chk("coin_fs3_sel",   32'(pat_sel),   32'd3);
        frame(100, 0, 2'd0, 24'd0);
        chk("coin_fs4_on",    32'(video_en),  32'd1);

        // Frames stop while blanking: watchdog restores video with the new mode.
        step(1, 2'd0, 24'h123456, 0);
        frame(100, 0, 2'd0, 24'd0);
        repeat (195) step(0, 2'd0, 24'd0, 0);
        chk("wd_pre_err",     32'(timeout_err), 32'd0);
        chk("wd_pre_video",   32'(video_en),    32'd0);
        repeat (10) step(0, 2'd0, 24'd0, 0);
        chk("wd_err",         32'(timeout_err), 32'd1);
        chk("wd_video",       32'(video_en),    32'd1);
        chk("wd_sel",         32'(pat_sel),     32'd0);
        chk("wd_color",       32'(pat_color),   32'h123456);
        chk("wd_ready",       32'(cfg_ready),   32'd1);
        frame(20, 0, 2'd0, 24'd0);
        frame(100, 0, 2'd0, 24'd0);
        chk("wd_sticky",      32'(timeout_err), 32'd1);

        // Reset in the middle of blanking, then frame counter wrap.
        step(1, 2'd2, 24'hABCDEF, 0);
        frame(100, 0, 2'd0, 24'd0);
        frame(100, 0, 2'd0, 24'd0);
        do_reset();
        repeat (65535) step(0, 2'd0, 24'd0, 1);
        chk("fcnt_ffff",      32'(frame_cnt), 32'hFFFF);
        step(0, 2'd0, 24'd0, 1);
        chk("fcnt_wrap",      32'(frame_cnt), 32'd0);

        // Random traffic, with occasional frame gaps long enough to trip the watchdog.
        gap = $urandom_range(1, 140);
        for (int i = 0; i < 3000; i++) begin
            gap--;
            fs = (gap == 0);
            if (fs) gap = ($urandom_range(0, 19) == 0) ? 260 : $urandom_range(1, 140);
            step($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), 24'($urandom), fs);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
